// File: rtl/icache_refill_controller_pkg.sv
// rtl/icache_refill_controller_pkg.sv - FetchUnitTypes: refill FSM state, line geometry and line-address helper
package FetchUnitTypes;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } IcRefillState;

  localparam int ICACHE_LINE_BEATS        = 4;
  localparam int ICACHE_BEAT_WIDTH        = 64;
  localparam int ICACHE_LINE_OFFSET_WIDTH = $clog2(ICACHE_LINE_BEATS * ICACHE_BEAT_WIDTH / 8);

  // Clears the byte-offset-within-line bits of an address.
  function automatic logic [63:0] ToLineAddr(input logic [63:0] addr, input int offset_width);
    logic [63:0] mask;
    mask = ~((64'd1 << offset_width) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/icache_refill_controller_beat_counter.sv
// rtl/icache_refill_controller_beat_counter.sv - refill beat index counter with last-beat detect
module icache_refill_beat_counter
  import FetchUnitTypes::*;
#(
  parameter int LINE_BEATS = ICACHE_LINE_BEATS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          inc,
  output logic [$clog2(LINE_BEATS)-1:0] count,
  output logic                          last
);

  localparam int CW = $clog2(LINE_BEATS);

  logic [CW-1:0] count_q, count_d;

  // Next count: cleared at the start of a fill, stepped per accepted beat; wraps naturally.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register, asynchronously cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CW'(LINE_BEATS - 1));

endmodule

// File: rtl/icache_refill_controller.sv
// rtl/icache_refill_controller.sv - I-cache line refill sequencer; optional RSD_ICACHE_REFILL_PERF_COUNTER_EN adds perf counters
module icache_refill_controller
  import FetchUnitTypes::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = ICACHE_BEAT_WIDTH,
  parameter int LINE_BEATS = ICACHE_LINE_BEATS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          icRE,
  input  logic                          icReadHit,
  input  logic [ADDR_WIDTH-1:0]         icReadAddr,
  input  logic                          flush,
  output logic                          memReq,
  output logic [ADDR_WIDTH-1:0]         memReqAddr,
  input  logic                          memReqAck,
  input  logic                          memRspValid,
  input  logic [BEAT_WIDTH-1:0]         memRspData,
  output logic                          fillWE,
  output logic [ADDR_WIDTH-1:0]         fillAddr,
  output logic [$clog2(LINE_BEATS)-1:0] fillBeat,
  output logic [BEAT_WIDTH-1:0]         fillData,
  output logic                          fillTagWE,
  output logic                          missStall,
  output logic                          busy
`ifdef RSD_ICACHE_REFILL_PERF_COUNTER_EN
  ,
  output logic [31:0]                   perfMissCount,
  output logic [31:0]                   perfStallCycles
`endif
);

  localparam int OFFSET_W = $clog2(LINE_BEATS * BEAT_WIDTH / 8);

  IcRefillState          state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic                  mem_req_q, mem_req_d;

  logic                  miss;
  logic                  miss_start;
  logic                  req_accept;
  logic                  beat_fire;
  logic                  beat_last;
  logic [$clog2(LINE_BEATS)-1:0] beat_idx;

  assign miss       = (state_q == IDLE) && icRE && !icReadHit && !flush;
  assign miss_start = miss;
  assign req_accept = (state_q == REQ) && mem_req_q && memReqAck;
  // Response beats only count while filling; strays in other states are dropped.
  assign beat_fire  = (state_q == FILL) && memRspValid;

  icache_refill_beat_counter #(
    .LINE_BEATS(LINE_BEATS)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (req_accept),
    .inc  (beat_fire),
    .count(beat_idx),
    .last (beat_last)
  );

  // Next-state logic; flush only gates miss start, never aborts an in-flight refill.
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    mem_req_d   = mem_req_q;
    case (state_q)
      IDLE: begin
        if (miss_start) begin
          line_addr_d = ADDR_WIDTH'(ToLineAddr(64'(icReadAddr), OFFSET_W));
          mem_req_d   = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (req_accept) begin
          mem_req_d = 1'b0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (beat_fire && beat_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM register with registered request output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      mem_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      mem_req_q   <= mem_req_d;
    end
  end

  assign memReq     = mem_req_q;
  assign memReqAddr = line_addr_q;
  assign fillAddr   = line_addr_q;
  assign fillWE     = beat_fire;
  assign fillBeat   = beat_idx;
  assign fillData   = beat_fire ? memRspData : '0;
  assign fillTagWE  = beat_fire && beat_last;
  assign busy       = (state_q != IDLE);
  // Gated by rst so every output reads 0 while reset is held, even with a lookup missing.
  assign missStall  = rst && ((state_q != IDLE) || miss);

`ifdef RSD_ICACHE_REFILL_PERF_COUNTER_EN
  logic [31:0] perf_miss_q, perf_miss_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating event counters for refill starts and stalled cycles.
  always_comb begin
    perf_miss_d  = perf_miss_q;
    perf_stall_d = perf_stall_q;
    if (miss_start && (perf_miss_q != '1)) begin
      perf_miss_d = perf_miss_q + 32'd1;
    end
    if (missStall && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_miss_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_miss_q  <= perf_miss_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perfMissCount   = perf_miss_q;
  assign perfStallCycles = perf_stall_q;
`endif

endmodule

// File: doc/icache_refill_controller.md
# icache_refill_controller

Sequences I-cache line refills for the fetch stage. When the fetch-stage tag check misses, it:
- issues a single line-aligned read request to the memory side;
- collects the response beats and writes them into the I-cache data array;
- validates the tag on the last beat;
- holds the fetch stage stalled until the retried lookup can hit.

It sits between the fetch stage's I-cache port and the memory interface.

## Interface
Parameters:
- ADDR_WIDTH, 32, physical address width
- BEAT_WIDTH, 64, memory response data width
- LINE_BEATS, 4, beats per cache line (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low (rst==0 resets)
- icRE  in  1  fetch-stage lookup valid
- icReadHit  in  1  tag-check hit for current lookup
- icReadAddr  in  ADDR_WIDTH  physical lookup address
- flush  in  1  fetch-stage clear
- memReq  out  1  read request valid
- memReqAddr  out  ADDR_WIDTH  line-aligned request address
- memReqAck  in  1  request accepted (when memReq=1)
- memRspValid  in  1  response beat valid
- memRspData  in  BEAT_WIDTH  response beat data
- fillWE  out  1  data-array write enable
- fillAddr  out  ADDR_WIDTH  line address being filled
- fillBeat  out  $clog2(LINE_BEATS)  beat index written
- fillData  out  BEAT_WIDTH  beat data
- fillTagWE  out  1  tag write/validate for fillAddr
- missStall  out  1  stall request to fetch stage
- busy  out  1  state != IDLE

## Operation
FSM states: IDLE, REQ, FILL, DONE.

- **IDLE**
  - miss = icRE && !icReadHit && !flush.
  - On miss: latch line-aligned icReadAddr (low log2(LINE_BEATS·BEAT_WIDTH/8) bits cleared) into lineAddr, then → REQ.
- **REQ**
  - memReq=1; memReqAddr=lineAddr, held stable.
  - Request is accepted in the cycle memReq && memReqAck; then → FILL with beat counter=0.
  - The request is never withdrawn.
- **FILL**
  - Each memRspValid cycle gives fillWE=1, fillBeat=counter, fillData=memRspData (combinational pass-through); the counter then increments.
  - The beat with counter==LINE_BEATS-1 also gives fillTagWE=1, then → DONE.
  - Counter width is $clog2(LINE_BEATS) and wraps to 0 on the last beat.
- **DONE**: one cycle for array writes to settle, then unconditionally → IDLE. No new miss is accepted in DONE.
- **Outputs outside the above**
  - memRspValid in IDLE/REQ/DONE is ignored.
  - fillAddr=lineAddr at all times; memReqAddr=lineAddr at all times.
  - missStall = (state != IDLE) || miss.
- **Flush**
  - Flush in IDLE suppresses miss start.
  - Flush in REQ/FILL/DONE does not abort; the line is still filled and validated.
  - missStall still holds until DONE completes, so the memory handshake is never orphaned.
- **Reset** (any state, async)
  - State → IDLE; counter, lineAddr → 0.
  - All outputs 0.
  - Response beats arriving after reset are ignored.

## Timing
- Miss in cycle T (IDLE): missStall=1 in T (combinational); memReq=1 from T+1.
- Ack in cycle A: state FILL in A+1; a beat may arrive in A+1 at the earliest.
- Last beat in cycle L: fillWE=fillTagWE=1 in L; DONE in L+1; IDLE in L+2.
  - missStall=0 in L+2 unless the retried lookup misses again.
- Minimum miss penalty with immediate ack and back-to-back beats: 1 + LINE_BEATS + 1 cycles of stall after T.
- No output other than missStall depends combinationally on icRE or icReadHit. Fill outputs depend combinationally on memRspValid/memRspData in FILL.

## Configuration
- RSD_ICACHE_REFILL_PERF_COUNTER_EN defined: adds outputs perfMissCount (32) and perfStallCycles (32).
  - perfMissCount increments on each IDLE→REQ transition.
  - perfStallCycles increments each cycle missStall=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package (FetchUnitTypes):
  - state enum IcRefillState {IDLE, REQ, FILL, DONE};
  - ICACHE_LINE_BEATS constant;
  - line-offset width constant;
  - ToLineAddr() helper.
- Optional sub-module icache_refill_beat_counter (counter + last-beat detect); all else inline.

## Test plan
- **Single miss**:
  - Stimulus: icRE=1, icReadHit=0, icReadAddr=0x0000_1234; ack after 2 cycles; 4 consecutive beats D0..D3.
  - Required response: memReqAddr=0x0000_1220; fillBeat 0..3 with D0..D3; fillTagWE on beat 3; missStall deasserts 2 cycles after the last beat.
- **Gapped beats**: same miss with 3 idle cycles between beats. Required response: fillWE only on valid cycles; counter holds across gaps.
- **Flush during FILL after beat 1**: refill completes all 4 beats; fillTagWE=1; returns to IDLE.
- **Flush with miss in IDLE** (same cycle): memReq stays 0; missStall=0.
- **Reset mid-FILL after beat 2** (rst=0 asynchronously): all outputs 0 immediately. After release, a late memRspValid gives no fillWE.
- **Perf counters** (macro defined), two misses each with 6 stall cycles: perfMissCount=2, perfStallCycles=12.
